// File: rtl/chacha_block_core.sv
// chacha_block_core: iterative ChaCha block function, one column or diagonal round per clock.
// chacha_qr is the combinational quarter round shared by the round datapath.
module chacha_qr (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  input  logic [31:0] d,
  output logic [31:0] na,
  output logic [31:0] nb,
  output logic [31:0] nc,
  output logic [31:0] nd
);
  logic [31:0] a1, b1, c1, d1, t1, t2, t3, t4;
  assign a1 = a + b;
  assign t1 = d ^ a1;
  assign d1 = {t1[15:0], t1[31:16]};
  assign c1 = c + d1;
  assign t2 = b ^ c1;
  assign b1 = {t2[19:0], t2[31:20]};
  assign na = a1 + b1;
  assign t3 = d1 ^ na;
  assign nd = {t3[23:0], t3[31:24]};
  assign nc = c1 + nd;
  assign t4 = b1 ^ nc;
  assign nb = {t4[24:0], t4[31:25]};
endmodule

module chacha_block_core #(
  parameter int ROUNDS = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [255:0] key,
  input  logic [31:0]  counter,
  input  logic [95:0]  nonce,
  input  logic         out_ready,
  output logic [511:0] keystream,
  output logic         out_valid,
  output logic         busy
);
  localparam int RW = $clog2(ROUNDS + 1);
  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;
  state_t state, state_d;
  logic [15:0][31:0] init, work, nw, sum;
  logic [3:0][31:0] ra, rb, rc, rd;
  logic [RW-1:0] rnd;
  logic odd, fin;
  logic [511:0] init_state;
  assign init_state = {nonce, counter, key, 32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};
  assign odd = rnd[0];
  assign fin = rnd == RW'(ROUNDS);
  assign busy = state != IDLE;
  assign out_valid = state == DONE;
  // Odd rounds pick diagonals as inputs and scatter the results back to their diagonal slots.
  for (genvar q = 0; q < 4; q++) begin : g_qr
    chacha_qr u_qr (
      .a (work[q]),
      .b (odd ? work[4 + (q + 1) % 4]  : work[4 + q]),
      .c (odd ? work[8 + (q + 2) % 4]  : work[8 + q]),
      .d (odd ? work[12 + (q + 3) % 4] : work[12 + q]),
      .na(ra[q]),
      .nb(rb[q]),
      .nc(rc[q]),
      .nd(rd[q])
    );
    assign nw[q]      = ra[q];
    assign nw[4 + q]  = odd ? rb[(q + 3) % 4] : rb[q];
    assign nw[8 + q]  = odd ? rc[(q + 2) % 4] : rc[q];
    assign nw[12 + q] = odd ? rd[(q + 1) % 4] : rd[q];
  end
  for (genvar i = 0; i < 16; i++) begin : g_sum
    assign sum[i] = work[i] + init[i];
  end
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = start ? ROUND : IDLE;
      ROUND:   state_d = fin ? DONE : ROUND;
      DONE:    state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      init      <= '0;
      work      <= '0;
      rnd       <= '0;
      keystream <= '0;
    end else begin
      state <= state_d;
      if (state == IDLE && start) begin
        init <= init_state;
        work <= init_state;
        rnd  <= '0;
      end else if (state == ROUND && !fin) begin
        work <= nw;
        rnd  <= rnd + RW'(1);
      end else if (state == ROUND) begin
        keystream <= sum;
      end
    end
  end
endmodule
